// File: rtl/scrambler_pkg.sv
// Shared types and constants for the parallel LFSR scrambler family.
// The default polynomial is the 12-bit FEC-chain polynomial with taps 11, 5, 3 and 0.
`timescale 1ns/1ps
package scrambler_pkg;

  typedef enum logic [1:0] {
    SCR_ADD  = 2'd0,
    SCR_SS   = 2'd1,
    DESCR_SS = 2'd2
  } scr_mode_e;

  localparam int          DEF_LFSR_LEN = 12;
  localparam logic [31:0] DEF_TAPS     = 32'h0000_0829;
  localparam logic [31:0] DEF_SEED     = 32'h0000_0FFF;

  function automatic logic parity(input logic [63:0] v);
    parity = ^v;
  endfunction

endpackage

// File: rtl/lfsr_par_core.sv
// Combinational core: advances the LFSR DATA_W steps in one cycle, MSB of data_in first.
// It holds no state, so multi-lane variants can chain several copies.
`timescale 1ns/1ps
module lfsr_par_core
  import scrambler_pkg::*;
#(
  parameter int                  LFSR_LEN = DEF_LFSR_LEN,
  parameter logic [LFSR_LEN-1:0] TAPS     = DEF_TAPS[LFSR_LEN-1:0],
  parameter int                  DATA_W   = 8,
  parameter int                  MODE     = 0
) (
  input  logic [LFSR_LEN-1:0] state_in,
  input  logic [DATA_W-1:0]   data_in,
  output logic [LFSR_LEN-1:0] state_out,
  output logic [DATA_W-1:0]   data_out
);

  localparam logic [1:0] MODE_BITS = MODE[1:0];
  localparam scr_mode_e  MODE_E    = scr_mode_e'(MODE_BITS);

  logic [LFSR_LEN-1:0] s;
  logic                p;
  logic                fb;

  // The register shifts left, so state bit i is the feedback bit from i+1 steps back.
  always_comb begin
    s        = state_in;
    p        = 1'b0;
    fb       = 1'b0;
    data_out = '0;
    for (int k = DATA_W - 1; k >= 0; k--) begin
      p           = parity(64'(s & TAPS));
      data_out[k] = data_in[k] ^ p;
      case (MODE_E)
        SCR_SS:   fb = data_in[k] ^ p;
        DESCR_SS: fb = data_in[k];
        default:  fb = p;
      endcase
      s = {s[LFSR_LEN-2:0], fb};
    end
    state_out = s;
  end

endmodule

// File: rtl/lfsr_scrambler_par.sv
// Parallel LFSR scrambler/descrambler with valid/ready flow control, sop reseed and per-beat bypass.
// It has a single output register and no skid buffer, so ready is combinational from downstream.
`timescale 1ns/1ps
module lfsr_scrambler_par
  import scrambler_pkg::*;
#(
  parameter int          LFSR_LEN      = DEF_LFSR_LEN,
  parameter logic [31:0] TAPS          = DEF_TAPS,
  parameter logic [31:0] SEED          = DEF_SEED,
  parameter int          DATA_W        = 8,
  parameter int          MODE          = 0,
  parameter int          RESEED_ON_SOP = 1
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              ival,
  output logic              ordy_in,
  input  logic              isop,
  input  logic              ieop,
  input  logic              ibypass,
  input  logic [DATA_W-1:0] idata,
  output logic              oval,
  input  logic              irdy_out,
  output logic              osop,
  output logic              oeop,
  output logic [DATA_W-1:0] odata
);

  localparam logic [LFSR_LEN-1:0] TAPS_L    = TAPS[LFSR_LEN-1:0];
  localparam logic [LFSR_LEN-1:0] SEED_L    = SEED[LFSR_LEN-1:0];
  localparam bit                  DO_RESEED = (RESEED_ON_SOP != 0);

  if (LFSR_LEN < 2 || LFSR_LEN > 32) begin : g_err_len
    $error("lfsr_scrambler_par: LFSR_LEN must be 2..32");
  end
  if (DATA_W < 1 || DATA_W > 64) begin : g_err_dw
    $error("lfsr_scrambler_par: DATA_W must be 1..64");
  end
  if ((TAPS >> LFSR_LEN) != 32'd0) begin : g_err_taps_hi
    $error("lfsr_scrambler_par: TAPS has a bit at or above LFSR_LEN");
  end
  if (TAPS == 32'd0) begin : g_err_taps_zero
    $error("lfsr_scrambler_par: TAPS must be nonzero");
  end
  if (MODE < 0 || MODE > 2) begin : g_err_mode
    $error("lfsr_scrambler_par: MODE must be 0, 1 or 2");
  end
  if (MODE == 0 && SEED_L == '0) begin : g_err_seed
    $error("lfsr_scrambler_par: additive mode would lock up with a zero SEED");
  end

  logic [LFSR_LEN-1:0] state;
  logic [LFSR_LEN-1:0] base_state;
  logic [LFSR_LEN-1:0] core_state;
  logic [DATA_W-1:0]   core_data;
  logic                accept;

  assign ordy_in    = ~oval | irdy_out;
  assign accept     = ival & ordy_in;
  assign base_state = (isop && DO_RESEED) ? SEED_L : state;

  lfsr_par_core #(
    .LFSR_LEN (LFSR_LEN),
    .TAPS     (TAPS_L),
    .DATA_W   (DATA_W),
    .MODE     (MODE)
  ) u_core (
    .state_in  (base_state),
    .data_in   (idata),
    .state_out (core_state),
    .data_out  (core_data)
  );

  // A bypassed beat still honours the sop reseed but leaves the keystream position untouched.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state <= SEED_L;
      oval  <= 1'b0;
      osop  <= 1'b0;
      oeop  <= 1'b0;
      odata <= '0;
    end else if (accept) begin
      state <= ibypass ? base_state : core_state;
      oval  <= 1'b1;
      osop  <= isop;
      oeop  <= ieop;
      odata <= ibypass ? idata : core_data;
    end else if (irdy_out) begin
      oval  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_scrambler_par.sv
// Scoreboard bench: an additive instance under backpressure, bypass and reset, plus a
// self-sync scrambler feeding a self-sync descrambler for round-trip and error spreading.
`timescale 1ns/1ps
module tb_lfsr_scrambler_par;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } beat_t;

  logic       iclk = 1'b0;
  logic       ireset, ival, isop, ieop, ibypass, irdy_out;
  logic [7:0] idata;
  logic       ordy_in, oval, osop, oeop;
  logic [7:0] odata;

  logic       p_ival, p_sop, p_eop, p_byp, d_irdy;
  logic [7:0] p_data, flip_mask;
  logic       s_ordy, s_oval, s_osop, s_oeop;
  logic [7:0] s_odata, d_idata;
  logic       d_ordy, d_oval, d_osop, d_oeop;
  logic [7:0] d_odata;

  int checks = 0;
  int errors = 0;
  int stall_left = 0;
  bit rand_rdy = 0;
  int s_cnt = 0;
  int flip_target = -1;
  int diff_total = 0;

  beat_t      exp_q[$];
  beat_t      scr_q[$];
  beat_t      desc_q[$];
  logic [7:0] orig_q[$];

  // Reference keeps each model's past feedback bits; hist[m][0] is the most recent one.
  bit         hist [0:2][0:11];
  logic [11:0] taps_v = 12'h829;
  logic [11:0] seed_v = 12'hFFF;

  always #5 iclk = ~iclk;

  lfsr_scrambler_par dut (
    .iclk(iclk), .ireset(ireset), .ival(ival), .ordy_in(ordy_in), .isop(isop), .ieop(ieop),
    .ibypass(ibypass), .idata(idata), .oval(oval), .irdy_out(irdy_out), .osop(osop),
    .oeop(oeop), .odata(odata)
  );

  lfsr_scrambler_par #(.MODE(1)) scr (
    .iclk(iclk), .ireset(ireset), .ival(p_ival), .ordy_in(s_ordy), .isop(p_sop), .ieop(p_eop),
    .ibypass(p_byp), .idata(p_data), .oval(s_oval), .irdy_out(d_ordy), .osop(s_osop),
    .oeop(s_oeop), .odata(s_odata)
  );

  assign d_idata = s_odata ^ flip_mask;

  lfsr_scrambler_par #(.MODE(2)) desc (
    .iclk(iclk), .ireset(ireset), .ival(s_oval), .ordy_in(d_ordy), .isop(s_osop), .ieop(s_oeop),
    .ibypass(p_byp), .idata(d_idata), .oval(d_oval), .irdy_out(d_irdy), .osop(d_osop),
    .oeop(d_oeop), .odata(d_odata)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void seedModel(input int m);
    for (int i = 0; i < 12; i++) hist[m][i] = seed_v[i];
  endfunction

  // m: 0 additive, 1 self-sync scramble, 2 self-sync descramble.
  function automatic logic [7:0] modelBeat(input int m, input logic [7:0] d, input logic sop,
                                           input logic byp);
    logic [7:0] o;
    bit fb, nb;
    o = d;
    if (sop) seedModel(m);
    if (byp) return d;
    for (int k = 7; k >= 0; k--) begin
      fb = 0;
      for (int i = 0; i < 12; i++) if (taps_v[i]) fb ^= hist[m][i];
      o[k] = d[k] ^ fb;
      nb = (m == 0) ? fb : (m == 1) ? o[k] : d[k];
      for (int i = 11; i > 0; i--) hist[m][i] = hist[m][i-1];
      hist[m][0] = nb;
    end
    return o;
  endfunction

  task automatic applyStimulus(input logic sop, input logic eop, input logic byp,
                               input logic [7:0] d);
    int waited = 0;
    beat_t b;
    @(negedge iclk);
    ival = 1; isop = sop; ieop = eop; ibypass = byp; idata = d;
    while (!ordy_in && waited < 50) begin
      @(negedge iclk);
      waited++;
    end
    if (!ordy_in) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: ordy_in stayed 0, expected 1 within 50 cycles");
      ival = 0;
      return;
    end
    b.sop = sop; b.eop = eop; b.data = modelBeat(0, d, sop, byp);
    exp_q.push_back(b);
    @(posedge iclk);
    #1 ival = 0;
  endtask

  task automatic doReset();
    @(negedge iclk);
    ireset = 1; ival = 0; p_ival = 0;
    @(posedge iclk);
    #1;
    exp_q.delete();
    for (int m = 0; m < 3; m++) seedModel(m);
    @(negedge iclk);
    checkOutput("reset_oval", oval, 0);
    ireset = 0;
  endtask

  task automatic pairRun(input int n, input int flip_idx);
    beat_t b;
    s_cnt = 0; flip_target = flip_idx; diff_total = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      p_ival = 1; p_sop = (i == 0); p_eop = (i == n - 1); p_data = 8'($urandom);
      b.sop = p_sop; b.eop = p_eop; b.data = modelBeat(1, p_data, p_sop, 1'b0);
      scr_q.push_back(b);
      orig_q.push_back(p_data);
    end
    @(negedge iclk);
    p_ival = 0;
    repeat (6) @(negedge iclk);
  endtask

  // Downstream ready: a forced stall window, random toggling, or always ready.
  initial forever begin
    @(posedge iclk);
    #2;
    if (stall_left > 0) begin
      irdy_out = 0;
      stall_left--;
    end else if (rand_rdy) irdy_out = ($urandom_range(0, 2) != 0);
    else irdy_out = 1;
  end

  // Additive-instance monitor: transfers pop the scoreboard, stalls must hold the output.
  initial begin
    bit         held = 0;
    logic [9:0] held_v;
    beat_t      e;
    forever begin
      @(negedge iclk);
      checkOutput("ordy_rule", ordy_in, !oval || irdy_out);
      if (held) checkOutput("stall_hold", {oval, osop, oeop, odata}, {1'b1, held_v});
      if (oval && irdy_out) begin
        held = 0;
        if (exp_q.size() == 0) checkOutput("unexpected_beat", {oval, odata}, {1'b0, 8'h00});
        else begin
          e = exp_q.pop_front();
          checkOutput("beat", {osop, oeop, odata}, {e.sop, e.eop, e.data});
        end
      end else if (oval) begin
        held = 1;
        held_v = {osop, oeop, odata};
      end else held = 0;
    end
  end

  // Chain monitor: checks scrambler output, injects the flip, checks descrambler output.
  initial begin
    beat_t      e;
    logic [7:0] fm, orig;
    forever begin
      @(negedge iclk);
      if (d_oval) begin
        if (desc_q.size() == 0 || orig_q.size() == 0)
          checkOutput("desc_unexpected", {d_oval, d_odata}, {1'b0, 8'h00});
        else begin
          e = desc_q.pop_front();
          orig = orig_q.pop_front();
          checkOutput("desc_beat", {d_osop, d_oeop, d_odata}, {e.sop, e.eop, e.data});
          if (flip_target < 0) checkOutput("roundtrip", d_odata, orig);
          else diff_total += $countones(d_odata ^ orig);
        end
      end
      fm = 8'h00;
      if (s_oval) begin
        checkOutput("scr_ordy", s_ordy, 1);
        if (scr_q.size() == 0) checkOutput("scr_unexpected", {s_oval, s_odata}, {1'b0, 8'h00});
        else begin
          e = scr_q.pop_front();
          checkOutput("scr_beat", {s_osop, s_oeop, s_odata}, {e.sop, e.eop, e.data});
          if (s_cnt == flip_target) fm = 8'h10;
          e.data = modelBeat(2, e.data ^ fm, e.sop, 1'b0);
          desc_q.push_back(e);
        end
        s_cnt++;
      end
      flip_mask = fm;
    end
  end

  initial begin
    logic [7:0] d;
    int         wait_cnt;
    ireset = 1; ival = 0; isop = 0; ieop = 0; ibypass = 0; idata = 0; irdy_out = 1;
    p_ival = 0; p_sop = 0; p_eop = 0; p_byp = 0; p_data = 0; d_irdy = 1; flip_mask = 0;
    for (int m = 0; m < 3; m++) seedModel(m);
    repeat (2) @(negedge iclk);
    doReset();
    checkOutput("reset_odata", odata, 8'h00);
    checkOutput("reset_osop_oeop", {osop, oeop}, 2'b00);
    checkOutput("reset_ordy", ordy_in, 1);

    $display("[TB] keystream and reseed");
    applyStimulus(1, 0, 0, 8'h00);
    @(negedge iclk);
    checkOutput("keystream_first", odata, 8'h5A);
    checkOutput("keystream_osop", osop, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, i == 2, 0, 8'($urandom));
    applyStimulus(1, 0, 0, 8'h00);
    @(negedge iclk);
    checkOutput("reseed_sop", odata, 8'h5A);

    $display("[TB] bypass");
    applyStimulus(1, 0, 0, 8'($urandom));
    d = 8'($urandom);
    applyStimulus(0, 0, 1, d);
    @(negedge iclk);
    checkOutput("bypass_passthru", odata, d);
    applyStimulus(0, 0, 0, 8'($urandom));
    applyStimulus(0, 1, 0, 8'($urandom));

    $display("[TB] backpressure");
    repeat (3) @(negedge iclk);
    stall_left = 5;
    @(posedge iclk);
    #3;
    applyStimulus(1, 0, 0, 8'($urandom));
    @(negedge iclk);
    checkOutput("bp_ordy_low", ordy_in, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, i == 4, 0, 8'($urandom));

    $display("[TB] reset mid-packet");
    applyStimulus(1, 0, 0, 8'($urandom));
    applyStimulus(0, 0, 0, 8'($urandom));
    applyStimulus(0, 0, 0, 8'($urandom));
    doReset();
    applyStimulus(0, 0, 0, 8'h00);
    @(negedge iclk);
    checkOutput("after_reset_keystream", odata, 8'h5A);

    $display("[TB] random traffic");
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge iclk);
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, 8'($urandom));
    end
    rand_rdy = 0;
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      @(negedge iclk);
      wait_cnt++;
    end
    checkOutput("drain_main", exp_q.size(), 0);

    $display("[TB] self-sync round trip");
    pairRun(1000, -1);
    pairRun(40, 10);
    // One flipped line bit corrupts its own output bit plus one more per tap.
    checkOutput("error_spread", diff_total, 1 + $countones(taps_v));
    checkOutput("drain_pair", scr_q.size() + desc_q.size() + orig_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
